// File: rtl/neuron_layer_delayed_param_if.sv
// Spike-stream bundle between the encoder, the delayed LIF layer and the next layer.
interface neuron_layer_delayed_param_if #(
    parameter int M  = 4,
    parameter int N  = 8,
    parameter int VW = 8
);
    logic            enable;
    logic            delay_tick;
    logic [M-1:0]    input_spikes;
    logic [N*VW-1:0] membrane_potential_out;
    logic [N-1:0]    output_spikes;

    modport master (
        output enable,
        output delay_tick,
        output input_spikes,
        input  membrane_potential_out,
        input  output_spikes
    );

    modport slave (
        input  enable,
        input  delay_tick,
        input  input_spikes,
        output membrane_potential_out,
        output output_spikes
    );
endinterface

// File: rtl/neuron_layer_delayed_param.sv
// N leaky integrate-and-fire neurons fully connected to M inputs, with per-synapse axonal delay.
// Optional macro SPIKE_COUNT_EN adds count_clear and per-neuron saturating 8-bit spike counters.
module neuron_layer_delayed_param #(
    parameter int M  = 4,
    parameter int N  = 8,
    parameter int WW = 4,
    parameter int VW = 8,
    parameter int DW = 3,
    parameter int RW = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    neuron_layer_delayed_param_if.slave   bus,
    input  logic [N*M*WW-1:0]             weights,
    input  logic [VW-1:0]                 threshold,
    input  logic [VW-1:0]                 decay,
    input  logic [RW-1:0]                 refractory_period,
    input  logic                          reset_mode,
    input  logic [N*M*DW-1:0]             delay_values,
    input  logic [N*M-1:0]                delay_en
`ifdef SPIKE_COUNT_EN
    ,
    input  logic                          count_clear,
    output logic [N*8-1:0]                spike_count
`endif
);

    localparam int HD = (1 << DW) - 1;
    // Wide enough that V + worst-case sum - decay never wraps.
    localparam int SW = VW + WW + $clog2(M + 1) + 2;

    logic [M-1:0][HD-1:0]  hist_r;
    logic [M-1:0][HD-1:0]  hist_nxt_s;
    logic [N*M-1:0]        eff_s;
    logic [DW-1:0]         dly_s;
    logic signed [SW-1:0]  sum_s [N];
    logic signed [SW-1:0]  raw_s [N];
    logic [VW-1:0]         sat_s [N];
    logic [N-1:0][VW-1:0]  v_r;
    logic [N-1:0][VW-1:0]  v_nxt_s;
    logic [N-1:0][RW-1:0]  refr_r;
    logic [N-1:0][RW-1:0]  refr_nxt_s;
    logic [N-1:0]          spk_r;
    logic [N-1:0]          spk_nxt_s;

    function automatic logic signed [SW-1:0] sext_w(input logic [WW-1:0] w);
        return {{(SW-WW){w[WW-1]}}, w};
    endfunction

    function automatic logic signed [SW-1:0] zext_v(input logic [VW-1:0] v);
        return {{(SW-VW){1'b0}}, v};
    endfunction

    function automatic logic [VW-1:0] sat_vw(input logic signed [SW-1:0] x);
        logic [VW-1:0] r;
        if (x[SW-1]) begin
            r = '0;
        end else if (|x[SW-2:VW]) begin
            r = '1;
        end else begin
            r = x[VW-1:0];
        end
        return r;
    endfunction

    // History shift candidate: newest sample enters slot 0.
    always_comb begin
        hist_nxt_s = '0;
        for (int m = 0; m < M; m++) begin
            hist_nxt_s[m][0] = bus.input_spikes[m];
            for (int k = 1; k < HD; k++) begin
                hist_nxt_s[m][k] = hist_r[m][k-1];
            end
        end
    end

    // Effective spike per synapse; delayed taps read pre-shift history and only on a tick.
    always_comb begin
        eff_s = '0;
        dly_s = '0;
        for (int i = 0; i < N*M; i++) begin
            dly_s = delay_values[i*DW +: DW];
            if (delay_en[i] && (dly_s != {DW{1'b0}})) begin
                eff_s[i] = bus.delay_tick & hist_r[i % M][dly_s - {{(DW-1){1'b0}}, 1'b1}];
            end else begin
                eff_s[i] = bus.input_spikes[i % M];
            end
        end
    end

    // Per-neuron integrate, clamp (before the threshold compare), fire and refractory update.
    always_comb begin
        sum_s      = '{default: '0};
        raw_s      = '{default: '0};
        sat_s      = '{default: '0};
        v_nxt_s    = '0;
        refr_nxt_s = '0;
        spk_nxt_s  = '0;
        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                if (eff_s[n*M+m]) begin
                    sum_s[n] = sum_s[n] + sext_w(weights[(n*M+m)*WW +: WW]);
                end else begin
                    sum_s[n] = sum_s[n];
                end
            end
            raw_s[n] = zext_v(v_r[n]) + sum_s[n] - zext_v(decay);
            sat_s[n] = sat_vw(raw_s[n]);
            if (refr_r[n] != {RW{1'b0}}) begin
                v_nxt_s[n]    = '0;
                refr_nxt_s[n] = refr_r[n] - {{(RW-1){1'b0}}, 1'b1};
                spk_nxt_s[n]  = 1'b0;
            end else if ((threshold != {VW{1'b0}}) && (sat_s[n] >= threshold)) begin
                v_nxt_s[n]    = reset_mode ? (sat_s[n] - threshold) : {VW{1'b0}};
                refr_nxt_s[n] = refractory_period;
                spk_nxt_s[n]  = 1'b1;
            end else begin
                v_nxt_s[n]    = sat_s[n];
                refr_nxt_s[n] = '0;
                spk_nxt_s[n]  = 1'b0;
            end
        end
    end

    // State registers; history advances on tick independently of enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_r <= '0;
            v_r    <= '0;
            refr_r <= '0;
            spk_r  <= '0;
        end else begin
            if (bus.delay_tick) begin
                hist_r <= hist_nxt_s;
            end else begin
                hist_r <= hist_r;
            end
            if (bus.enable) begin
                v_r    <= v_nxt_s;
                refr_r <= refr_nxt_s;
                spk_r  <= spk_nxt_s;
            end else begin
                v_r    <= v_r;
                refr_r <= refr_r;
                spk_r  <= '0;
            end
        end
    end

    assign bus.membrane_potential_out = v_r;
    assign bus.output_spikes          = spk_r;

`ifdef SPIKE_COUNT_EN
    logic [N-1:0][7:0] cnt_r;

    // Saturating spike counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (count_clear) begin
            cnt_r <= '0;
        end else begin
            for (int n = 0; n < N; n++) begin
                if (bus.enable && spk_nxt_s[n] && (cnt_r[n] != 8'hFF)) begin
                    cnt_r[n] <= cnt_r[n] + 8'd1;
                end else begin
                    cnt_r[n] <= cnt_r[n];
                end
            end
        end
    end

    assign spike_count = cnt_r;
`endif

endmodule

// File: tb/tb_neuron_layer_delayed_param.sv
// Self-checking bench for neuron_layer_delayed_param: directed scenarios plus randomized
// runs compared against a behavioural layer model.
module tb_neuron_layer_delayed_param;
    localparam int M  = 4;
    localparam int N  = 8;
    localparam int WW = 4;
    localparam int VW = 8;
    localparam int DW = 3;
    localparam int RW = 4;
    localparam int HD = (1 << DW) - 1;

    logic              clk;
    logic              reset;
    logic [N*M*WW-1:0] weights;
    logic [VW-1:0]     threshold;
    logic [VW-1:0]     decay;
    logic [RW-1:0]     refractory_period;
    logic              reset_mode;
    logic [N*M*DW-1:0] delay_values;
    logic [N*M-1:0]    delay_en;
`ifdef SPIKE_COUNT_EN
    logic              count_clear;
    logic [N*8-1:0]    spike_count;
`endif

    neuron_layer_delayed_param_if #(.M(M), .N(N), .VW(VW)) bus ();

    neuron_layer_delayed_param #(
        .M(M), .N(N), .WW(WW), .VW(VW), .DW(DW), .RW(RW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .weights           (weights),
        .threshold         (threshold),
        .decay             (decay),
        .refractory_period (refractory_period),
        .reset_mode        (reset_mode),
        .delay_values      (delay_values),
        .delay_en          (delay_en)
`ifdef SPIKE_COUNT_EN
        ,
        .count_clear       (count_clear),
        .spike_count       (spike_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: potentials, refractory counts, spikes, spike counts, tick samples.
    int           mv [N];
    int           mr [N];
    bit           ms [N];
    int           mc [N];
    logic [M-1:0] mhist [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = 0; mr[n] = 0; ms[n] = 1'b0; mc[n] = 0;
        end
        mhist.delete();
        for (int k = 0; k < HD; k++) mhist.push_back('0);
    endfunction

    // One clock edge of the layer, evaluated from the rules with integer arithmetic.
    function automatic void model_step();
        int                 s_sum [N];
        int                 d, s, wi;
        bit                 e;
        logic signed [WW-1:0] ws;
        for (int n = 0; n < N; n++) begin
            s_sum[n] = 0;
            for (int m = 0; m < M; m++) begin
                d = int'(delay_values[(n*M+m)*DW +: DW]);
                if (delay_en[n*M+m] && d != 0) e = bus.delay_tick && mhist[d-1][m];
                else e = bus.input_spikes[m];
                ws = weights[(n*M+m)*WW +: WW];
                wi = ws;
                if (e) s_sum[n] += wi;
            end
        end
        for (int n = 0; n < N; n++) begin
            if (!bus.enable) begin
                ms[n] = 1'b0;
            end else if (mr[n] > 0) begin
                mr[n] -= 1; mv[n] = 0; ms[n] = 1'b0;
            end else begin
                s = mv[n] + s_sum[n] - int'(decay);
                if (s < 0) s = 0;
                if (s > (1 << VW) - 1) s = (1 << VW) - 1;
                if (threshold != 0 && s >= int'(threshold)) begin
                    ms[n] = 1'b1;
                    mv[n] = reset_mode ? s - int'(threshold) : 0;
                    mr[n] = int'(refractory_period);
                end else begin
                    ms[n] = 1'b0;
                    mv[n] = s;
                end
            end
`ifdef SPIKE_COUNT_EN
            if (count_clear) mc[n] = 0;
            else if (ms[n] && mc[n] < 255) mc[n] += 1;
`endif
        end
        if (bus.delay_tick) begin
            mhist.push_front(bus.input_spikes);
            void'(mhist.pop_back());
        end
    endfunction

    function automatic logic [N*VW-1:0] exp_mpo();
        logic [N*VW-1:0] r;
        for (int n = 0; n < N; n++) r[n*VW +: VW] = VW'(mv[n]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_spk();
        logic [N-1:0] r;
        for (int n = 0; n < N; n++) r[n] = ms[n];
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_w(input int n, input int m, input int val);
        weights[(n*M+m)*WW +: WW] = val[WW-1:0];
    endtask

    task automatic clear_cfg();
        weights = '0; delay_values = '0; delay_en = '0;
        threshold = '0; decay = '0; refractory_period = '0; reset_mode = 1'b0;
        bus.enable = 1'b0; bus.delay_tick = 1'b0; bus.input_spikes = '0;
`ifdef SPIKE_COUNT_EN
        count_clear = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        clear_cfg();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.membrane_potential_out !== '0) begin
            errors++; $display("FAIL reset_v got %h exp 0", bus.membrane_potential_out);
        end
        checks++;
        if (bus.output_spikes !== '0) begin
            errors++; $display("FAIL reset_spk got %b exp 0", bus.output_spikes);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_integrate_fire();
        logic [VW-1:0] ev [6] = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0};
        logic          es [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_cfg(); apply_reset();
        set_w(0, 0, 3); threshold = 8'd6; refractory_period = 4'd2;
        bus.input_spikes = 4'b0001; bus.enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (bus.membrane_potential_out[VW-1:0] !== ev[i]) begin
                errors++; $display("FAIL iaf_v step %0d got %0d exp %0d", i, bus.membrane_potential_out[VW-1:0], ev[i]);
            end
            checks++;
            if (bus.output_spikes[0] !== es[i]) begin
                errors++; $display("FAIL iaf_spk step %0d got %b exp %b", i, bus.output_spikes[0], es[i]);
            end
        end
    endtask

    task automatic test_no_refractory();
        clear_cfg(); apply_reset();
        set_w(0, 0, 3); threshold = 8'd3; refractory_period = 4'd0;
        bus.input_spikes = 4'b0001; bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.output_spikes[0] !== 1'b1 || bus.membrane_potential_out[VW-1:0] !== 8'd0) begin
                errors++; $display("FAIL norefr step %0d got spk %b v %0d exp spk 1 v 0", i, bus.output_spikes[0], bus.membrane_potential_out[VW-1:0]);
            end
        end
    endtask

    task automatic test_clamp();
        int ev;
        clear_cfg(); apply_reset();
        for (int m = 0; m < M; m++) set_w(1, m, 7);
        set_w(2, 0, -8);
        bus.input_spikes = 4'b1111; bus.enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cycle();
            ev = (28 * (i + 1) > 255) ? 255 : 28 * (i + 1);
            checks++;
            if (bus.membrane_potential_out[VW +: VW] !== VW'(ev)) begin
                errors++; $display("FAIL clamp_v1 step %0d got %0d exp %0d", i, bus.membrane_potential_out[VW +: VW], ev);
            end
            checks++;
            if (bus.membrane_potential_out[2*VW +: VW] !== 8'd0) begin
                errors++; $display("FAIL clamp_v2 step %0d got %0d exp 0", i, bus.membrane_potential_out[2*VW +: VW]);
            end
        end
    endtask

    task automatic test_delay();
        logic [VW-1:0] ev;
        clear_cfg(); apply_reset();
        set_w(3, 0, 5);
        delay_en[3*M] = 1'b1;
        delay_values[(3*M)*DW +: DW] = 3'd3;
        bus.enable = 1'b1;
        for (int c = 0; c < 28; c++) begin
            bus.delay_tick      = (c % 4 == 3);
            bus.input_spikes[0] = (c == 7);
            cycle();
            ev = (c >= 19) ? 8'd5 : 8'd0;
            checks++;
            if (bus.membrane_potential_out[3*VW +: VW] !== ev) begin
                errors++; $display("FAIL delay_v3 cyc %0d got %0d exp %0d", c, bus.membrane_potential_out[3*VW +: VW], ev);
            end
        end
        bus.delay_tick = 1'b0;
    endtask

    task automatic test_subtract_hold();
        clear_cfg(); apply_reset();
        reset_mode = 1'b1; threshold = 8'd10;
        set_w(4, 0, 7); set_w(4, 1, 6);
        bus.input_spikes = 4'b0011; bus.enable = 1'b1;
        cycle();
        checks++;
        if (bus.membrane_potential_out[4*VW +: VW] !== 8'd3 || bus.output_spikes[4] !== 1'b1) begin
            errors++; $display("FAIL subtract got v %0d spk %b exp v 3 spk 1", bus.membrane_potential_out[4*VW +: VW], bus.output_spikes[4]);
        end
        bus.enable = 1'b0;
        repeat (2) cycle();
        checks++;
        if (bus.membrane_potential_out[4*VW +: VW] !== 8'd3 || bus.output_spikes !== '0) begin
            errors++; $display("FAIL hold got v %0d spk %b exp v 3 spk 0", bus.membrane_potential_out[4*VW +: VW], bus.output_spikes);
        end
    endtask

    task automatic test_random(input int ncyc);
        for (int i = 0; i < N*M; i++) begin
            set_w(i / M, i % M, int'($urandom_range(0, 15)));
            delay_values[i*DW +: DW] = DW'($urandom_range(0, HD));
            delay_en[i] = ($urandom_range(0, 1) == 1);
        end
        threshold = VW'($urandom_range(0, 40));
        decay = VW'($urandom_range(0, 3));
        refractory_period = RW'($urandom_range(0, 3));
        reset_mode = ($urandom_range(0, 1) == 1);
        for (int c = 0; c < ncyc; c++) begin
            bus.input_spikes = M'($urandom_range(0, (1 << M) - 1));
            bus.delay_tick = ($urandom_range(0, 2) == 0);
            bus.enable = ($urandom_range(0, 9) != 0);
            cycle();
            checks++;
            if (bus.membrane_potential_out !== exp_mpo()) begin
                errors++; $display("FAIL rand_v cyc %0d got %h exp %h", c, bus.membrane_potential_out, exp_mpo());
            end
            checks++;
            if (bus.output_spikes !== exp_spk()) begin
                errors++; $display("FAIL rand_spk cyc %0d got %b exp %b", c, bus.output_spikes, exp_spk());
            end
        end
    endtask

    task automatic test_reset_midrun();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.membrane_potential_out !== '0 || bus.output_spikes !== '0) begin
            errors++; $display("FAIL midrun_reset got v %h spk %b exp 0", bus.membrane_potential_out, bus.output_spikes);
        end
        #1;
        reset = 1'b1;
        model_reset();
    endtask

`ifdef SPIKE_COUNT_EN
    task automatic test_spike_count();
        clear_cfg(); apply_reset();
        set_w(0, 0, 7); threshold = 8'd1;
        bus.input_spikes = 4'b0001; bus.enable = 1'b1;
        repeat (300) cycle();
        checks++;
        if (spike_count[7:0] !== 8'd255 || mc[0] != 255) begin
            errors++; $display("FAIL count_sat got %0d exp 255", spike_count[7:0]);
        end
        count_clear = 1'b1;
        cycle();
        count_clear = 1'b0;
        checks++;
        if (spike_count !== '0) begin
            errors++; $display("FAIL count_clear got %h exp 0", spike_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_integrate_fire();
        test_no_refractory();
        test_clamp();
        test_delay();
        test_subtract_hold();
        clear_cfg(); apply_reset();
        test_random(200);
        test_reset_midrun();
        test_random(200);
`ifdef SPIKE_COUNT_EN
        test_spike_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
